// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: control strobes, instruction-memory bus,
// decoded instruction fields and the performance counter.
// master = fetch_unit side, slave = control unit / memory / environment side.
interface fetch_unit_if;
    // control strobes and operands into the fetch unit
    logic        pc_inc;
    logic        pc_load;
    logic        pc_sel;
    logic        pc_rst_n;
    logic        ir_wr;
    logic        holt;
    logic [15:0] imem_rdata;
    logic [15:0] rs_val;

    // address, program counter and decoded fields out of the fetch unit
    logic [15:0] imem_addr;
    logic [15:0] pc_val;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic [15:0] link_addr;
    logic [15:0] instr_count;

    modport master (
        input  pc_inc, pc_load, pc_sel, pc_rst_n, ir_wr, holt, imem_rdata, rs_val,
        output imem_addr, pc_val, opcode, rd, rs, rt, imm, link_addr, instr_count
    );

    modport slave (
        output pc_inc, pc_load, pc_sel, pc_rst_n, ir_wr, holt, imem_rdata, rs_val,
        input  imem_addr, pc_val, opcode, rd, rs, rt, imm, link_addr, instr_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register and
// combinational field decode. The PC follows the priority
// holt > pc_rst_n > pc_load > pc_inc > hold; holt freezes every register.
// Optional feature: define FETCH_PERF_CNT_EN to build a saturating count of
// fetched instructions on instr_count; otherwise instr_count reads zero and
// no counter register exists.
module fetch_unit #(
    parameter int imem_size = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    // The PC is 16 bits wide, so the memory depth must fit its address range.
    generate
        if (imem_size < 1 || imem_size > 65536) begin : g_size_check
            $error("fetch_unit: imem_size must be in 1..65536");
        end
    endgenerate

    logic [15:0] pc_reg;
    logic [15:0] pc_next;
    logic [15:0] ir_reg;
    logic [15:0] ir_next;

    // Next PC: halt freezes, synchronous clear beats load, load beats increment.
    always_comb begin
        pc_next = pc_reg;
        if (!bus.holt) begin
            if (!bus.pc_rst_n) begin
                pc_next = 16'h0000;
            end else if (bus.pc_load) begin
                pc_next = bus.pc_sel ? bus.rs_val : {4'h0, ir_reg[11:0]};
            end else if (bus.pc_inc) begin
                pc_next = pc_reg + 16'd1;
            end
        end
    end

    // Next IR: capture the word addressed by the current (pre-update) PC.
    always_comb begin
        ir_next = ir_reg;
        if (!bus.holt && bus.ir_wr) begin
            ir_next = bus.imem_rdata;
        end
    end

    // PC register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= 16'h0000;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // Instruction register; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg <= 16'h0000;
        end else begin
            ir_reg <= ir_next;
        end
    end

    // Register-specifier nibbles: index 0 = rt, 1 = rs, 2 = rd.
    logic [2:0][3:0] reg_field;
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_field
            assign reg_field[gi] = ir_reg[gi*4 +: 4];
        end
    endgenerate

    assign bus.opcode    = ir_reg[15:12];
    assign bus.rd        = reg_field[2];
    assign bus.rs        = reg_field[1];
    assign bus.rt        = reg_field[0];
    assign bus.imm       = {8'h00, ir_reg[7:0]};
    assign bus.pc_val    = pc_reg;
    assign bus.imem_addr = pc_reg;
    assign bus.link_addr = pc_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] instr_count_reg;
    logic [15:0] instr_count_next;

    // Count every accepted fetch, sticking at the maximum instead of wrapping.
    always_comb begin
        instr_count_next = instr_count_reg;
        if (!bus.holt && bus.ir_wr && (instr_count_reg != 16'hFFFF)) begin
            instr_count_next = instr_count_reg + 16'd1;
        end
    end

    // Fetch counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_reg <= 16'h0000;
        end else begin
            instr_count_reg <= instr_count_next;
        end
    end

    assign bus.instr_count = instr_count_reg;
`else
    assign bus.instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Expected PC/IR/count triples are pushed
// to a scoreboard queue as each cycle is driven and popped after the edge.
module tb_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    fetch_unit_if bus ();

    fetch_unit #(.imem_size(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small instruction memory, read combinationally at imem_addr.
    logic [15:0] imem [0:31];
    always_comb bus.imem_rdata = imem[bus.imem_addr[4:0]];

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt;
    int          checks;
    int          errors;

    // Drive one cycle of strobes, pushing the expected state after the edge.
    task automatic drive(input logic inc, input logic load, input logic sel,
                         input logic prst, input logic irw, input logic hlt,
                         input logic [15:0] epc, input logic [15:0] eir);
        logic [15:0] ecnt;
        ecnt = exp_cnt;
        if (CNT_EN && irw && !hlt && exp_cnt != 16'hFFFF) ecnt = exp_cnt + 16'd1;
        sb.push_back('{pc: epc, ir: eir, cnt: ecnt});
        exp_cnt = ecnt;
        bus.pc_inc = inc; bus.pc_load = load; bus.pc_sel = sel;
        bus.pc_rst_n = prst; bus.ir_wr = irw; bus.holt = hlt;
        @(posedge clk);
        #1;
        bus.pc_inc = 1'b0; bus.pc_load = 1'b0; bus.pc_sel = 1'b0;
        bus.pc_rst_n = 1'b1; bus.ir_wr = 1'b0; bus.holt = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_cnt = 16'h0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        exp_cnt = 16'h0000;
        sb.push_back('{pc: 16'h0000, ir: 16'h0000, cnt: 16'h0000});
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 3;
        if ({bus.pc_val, bus.imem_addr, bus.link_addr} !== {3{e.pc}}) begin
            errors++; $display("FAIL reset_pc got %h want %h", bus.pc_val, e.pc);
        end
        if ({bus.opcode, bus.rd, bus.rs, bus.rt, bus.imm} !== {e.ir, 8'h00, e.ir[7:0]}) begin
            errors++; $display("FAIL reset_ir got %h%h%h%h want %h", bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
        end
        if (bus.instr_count !== e.cnt) begin
            errors++; $display("FAIL reset_cnt got %h want %h", bus.instr_count, e.cnt);
        end
        rst_n = 1'b1;
        // First edge after release already advances the PC.
        drive(1, 0, 0, 1, 0, 0, 16'h0001, 16'h0000);
        bus.rs_val = 16'h0007;
        drive(0, 1, 1, 1, 0, 0, 16'h0007, 16'h0000);
        imem[7] = 16'h5A5A;
        drive(0, 0, 0, 1, 1, 0, 16'h0007, 16'h5A5A);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            $display("txn reset_seq%0d pc=%h ir=%h", i, e.pc, e.ir);
        end
        // Mid-run asynchronous reset: outputs clear with no clock edge.
        rst_n = 1'b0;
        exp_cnt = 16'h0000;
        #2;
        checks += 3;
        if (bus.pc_val !== 16'h0000) begin
            errors++; $display("FAIL async_pc got %h want 0000", bus.pc_val);
        end
        if (bus.opcode !== 4'h0 || bus.imm !== 16'h0000) begin
            errors++; $display("FAIL async_ir got op=%h imm=%h want 0/0000", bus.opcode, bus.imm);
        end
        if (bus.instr_count !== 16'h0000) begin
            errors++; $display("FAIL async_cnt got %h want 0000", bus.instr_count);
        end
        $display("txn async_reset pc=%h op=%h", bus.pc_val, bus.opcode);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        exp_t e;
        bus.rs_val = 16'h0003;
        imem[3] = 16'hC123;
        drive(0, 1, 1, 1, 0, 0, 16'h0003, 16'h0000);
        drive(0, 0, 0, 1, 1, 0, 16'h0003, 16'hC123);
        drive(1, 0, 0, 1, 0, 0, 16'h0004, 16'hC123);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            $display("txn fetch%0d pc=%h ir=%h", i, e.pc, e.ir);
        end
        checks += 4;
        if (bus.pc_val !== e.pc) begin
            errors++; $display("FAIL fetch_pc got %h want %h", bus.pc_val, e.pc);
        end
        if (bus.opcode !== 4'hC) begin
            errors++; $display("FAIL fetch_opcode got %h want c", bus.opcode);
        end
        if (bus.rd !== 4'h1) begin
            errors++; $display("FAIL fetch_rd got %h want 1", bus.rd);
        end
        if (bus.imm !== 16'h0023) begin
            errors++; $display("FAIL fetch_imm got %h want 0023", bus.imm);
        end
    endtask

    task automatic test_jump();
        exp_t e;
        imem[4] = 16'h9015;
        drive(0, 0, 0, 1, 1, 0, 16'h0004, 16'h9015);
        drive(0, 1, 0, 1, 0, 0, 16'h0015, 16'h9015);
        bus.rs_val = 16'h0009;
        drive(0, 0, 1, 1, 0, 0, 16'h0015, 16'h9015);
        drive(0, 1, 1, 1, 0, 0, 16'h0009, 16'h9015);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            $display("txn jump%0d pc=%h ir=%h", i, e.pc, e.ir);
        end
        checks += 2;
        if ({bus.pc_val, bus.imem_addr, bus.link_addr} !== {3{e.pc}}) begin
            errors++; $display("FAIL jump_pc got %h want %h", bus.pc_val, e.pc);
        end
        if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== e.ir) begin
            errors++; $display("FAIL jump_ir got %h%h%h%h want %h", bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        bus.rs_val = 16'h001F;
        drive(0, 1, 1, 1, 0, 0, 16'h001F, 16'h9015);
        drive(1, 1, 0, 0, 0, 0, 16'h0000, 16'h9015);
        bus.rs_val = 16'h0005;
        drive(0, 1, 1, 1, 0, 0, 16'h0005, 16'h9015);
        imem[5] = 16'h0010;
        drive(0, 0, 0, 1, 1, 0, 16'h0005, 16'h0010);
        drive(1, 1, 0, 1, 0, 0, 16'h0010, 16'h0010);
        bus.rs_val = 16'h0009;
        drive(0, 1, 1, 1, 0, 0, 16'h0009, 16'h0010);
        imem[9] = 16'hA5B6; imem[10] = 16'h1111;
        drive(1, 0, 0, 1, 1, 0, 16'h000A, 16'hA5B6);
        bus.rs_val = 16'hFFFF;
        drive(0, 1, 1, 1, 0, 0, 16'hFFFF, 16'hA5B6);
        drive(1, 0, 0, 1, 0, 0, 16'h0000, 16'hA5B6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            $display("txn prio pc=%h ir=%h", e.pc, e.ir);
        end
        checks += 2;
        if (bus.pc_val !== e.pc) begin
            errors++; $display("FAIL wrap_pc got %h want %h", bus.pc_val, e.pc);
        end
        if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== e.ir) begin
            errors++; $display("FAIL prio_ir got %h%h%h%h want %h", bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
        end
    endtask

    // Each intermediate step is also checked, so priority faults are seen.
    task automatic test_priority_steps();
        exp_t e;
        logic [15:0] want_pc [0:4];
        want_pc[0] = 16'h001F; want_pc[1] = 16'h0000; want_pc[2] = 16'h0005;
        want_pc[3] = 16'h0010; want_pc[4] = 16'h000A;
        bus.rs_val = 16'h001F;
        drive(0, 1, 1, 1, 0, 0, want_pc[0], 16'hA5B6);
        e = sb.pop_front(); checks++;
        if (bus.pc_val !== e.pc) begin errors++; $display("FAIL prio_load31 got %h want %h", bus.pc_val, e.pc); end
        drive(1, 1, 0, 0, 0, 0, want_pc[1], 16'hA5B6);
        e = sb.pop_front(); checks++;
        if (bus.pc_val !== e.pc) begin errors++; $display("FAIL prio_clear got %h want %h", bus.pc_val, e.pc); end
        bus.rs_val = 16'h0005;
        drive(0, 1, 1, 1, 0, 0, want_pc[2], 16'hA5B6);
        e = sb.pop_front();
        drive(0, 0, 0, 1, 1, 0, want_pc[2], 16'h0010);
        e = sb.pop_front();
        drive(1, 1, 0, 1, 0, 0, want_pc[3], 16'h0010);
        e = sb.pop_front(); checks++;
        if (bus.pc_val !== e.pc) begin errors++; $display("FAIL prio_load_inc got %h want %h", bus.pc_val, e.pc); end
        bus.rs_val = 16'h0009;
        drive(0, 1, 1, 1, 0, 0, 16'h0009, 16'h0010);
        e = sb.pop_front();
        drive(1, 0, 0, 1, 1, 0, want_pc[4], 16'hA5B6);
        e = sb.pop_front(); checks += 2;
        if (bus.pc_val !== e.pc) begin errors++; $display("FAIL irwr_inc_pc got %h want %h", bus.pc_val, e.pc); end
        if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== e.ir) begin
            errors++; $display("FAIL irwr_inc_ir got %h%h%h%h want %h", bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
        end
        $display("txn prio_steps pc=%h ir=%h", e.pc, e.ir);
    endtask

    task automatic test_halt();
        exp_t e;
        logic [15:0] pc0;
        logic [15:0] ir0;
        pc0 = 16'h000A;
        ir0 = 16'hA5B6;
        imem[10] = 16'hFFFF;
        bus.rs_val = 16'h0003;
        for (int i = 0; i < 10; i++) begin
            drive(1, i[0], 1, i[1], 1, 1, pc0, ir0);
            e = sb.pop_front();
            checks += 3;
            if (bus.pc_val !== e.pc) begin
                errors++; $display("FAIL halt_pc cyc%0d got %h want %h", i, bus.pc_val, e.pc);
            end
            if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== e.ir) begin
                errors++; $display("FAIL halt_ir cyc%0d got %h%h%h%h want %h", i, bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
            end
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL halt_cnt cyc%0d got %h want %h", i, bus.instr_count, e.cnt);
            end
            $display("txn halt%0d pc=%h ir=%h cnt=%h", i, bus.pc_val, {bus.opcode, bus.rd, bus.rs, bus.rt}, bus.instr_count);
        end
        drive(0, 0, 0, 1, 1, 0, pc0, 16'hFFFF);
        e = sb.pop_front();
        checks++;
        if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== e.ir) begin
            errors++; $display("FAIL unhalt_ir got %h%h%h%h want %h", bus.opcode, bus.rd, bus.rs, bus.rt, e.ir);
        end
    endtask

    task automatic test_counter();
        exp_t e;
        apply_reset();
        imem[0] = 16'h7E81;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, 0, 16'h0000, 16'h7E81);
            e = sb.pop_front();
            $display("txn count%0d cnt=%h", i, bus.instr_count);
        end
        checks++;
        if (bus.instr_count !== (CNT_EN ? 16'd5 : 16'd0)) begin
            errors++; $display("FAIL count5 got %h want %h", bus.instr_count, CNT_EN ? 16'd5 : 16'd0);
        end
`ifdef FETCH_PERF_CNT_EN
        force dut.instr_count_reg = 16'hFFFD;
        #1;
        release dut.instr_count_reg;
        exp_cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1, 0, 16'h0000, 16'h7E81);
            e = sb.pop_front();
            checks++;
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL count_sat%0d got %h want %h", i, bus.instr_count, e.cnt);
            end
            $display("txn sat%0d cnt=%h", i, bus.instr_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 8; i++) imem[i] = 16'(i * 16'h1357) ^ 16'h8421;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1, 1, 0, 16'(i + 1), imem[i]);
            e = sb.pop_front();
            checks += 3;
            if ({bus.pc_val, bus.imem_addr, bus.link_addr} !== {3{e.pc}}) begin
                errors++; $display("FAIL b2b_pc%0d got %h want %h", i, bus.pc_val, e.pc);
            end
            if ({bus.opcode, bus.rd, bus.rs, bus.rt, bus.imm} !== {e.ir, 8'h00, e.ir[7:0]}) begin
                errors++; $display("FAIL b2b_ir%0d got %h%h%h%h imm=%h want %h", i, bus.opcode, bus.rd, bus.rs, bus.rt, bus.imm, e.ir);
            end
            if (bus.instr_count !== e.cnt) begin
                errors++; $display("FAIL b2b_cnt%0d got %h want %h", i, bus.instr_count, e.cnt);
            end
            $display("txn b2b%0d pc=%h ir=%h cnt=%h", i, bus.pc_val, {bus.opcode, bus.rd, bus.rs, bus.rt}, bus.instr_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 16'h0000;
        for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
        bus.pc_inc = 1'b0; bus.pc_load = 1'b0; bus.pc_sel = 1'b0;
        bus.pc_rst_n = 1'b1; bus.ir_wr = 1'b0; bus.holt = 1'b0;
        bus.rs_val = 16'h0000;
        rst_n = 1'b0;
        test_reset();
        test_fetch();
        test_jump();
        test_priority();
        test_priority_steps();
        test_halt();
        test_counter();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
